// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive side of the VGA timing path. Samples hsync/vsync/rgb on every pixel
//   strobe. Measures the line and frame lengths. Locks to the configured mode
//   after two consecutive good frames. While locked, emits the active pixels
//   with their recovered coordinates.
//
//   Optional feature macro: VGA_DEC_CRC_EN. When defined, the block adds a
//   CRC-16-CCITT over every valid pixel of each fully locked frame.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   pix_en       pixel strobe; the inputs are sampled only when this is 1
//   hsync/vsync  sync inputs; polarity is set by SYNC_NEG
//   rgb[11:0]    {R,G,B} pixel data
//   locked       decoder is locked to the mode
//   pix_valid    1-cycle pulse; pix_x/pix_y/pix_rgb hold an active pixel
//   pix_x/pix_y  active column/row, 0 when pix_valid=0
//   pix_rgb      last sampled pixel
//   frame_start  1-cycle pulse on each vsync leading edge
//   line_len     last measured line length, in pixels
//   frame_lines  last measured frame length, in lines
//   err_cnt      lock-loss count, saturating at 255
//   frame_crc    (VGA_DEC_CRC_EN) CRC of the last fully locked frame
//   crc_valid    (VGA_DEC_CRC_EN) 1-cycle pulse when frame_crc updates
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic [11:0] line_len,
  output logic [11:0] frame_lines,
  output logic [7:0]  err_cnt
`ifdef VGA_DEC_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT   = 12'(V_TOTAL);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_VERIFY, ST_LOCKED} state_t;

  state_t      state_reg, state_next;
  logic        hs_prev_reg, hs_prev_next;
  logic        vs_prev_reg, vs_prev_next;
  logic [11:0] hcnt_reg, hcnt_next;
  logic [11:0] ln_reg, ln_next;
  logic        bad_line_reg, bad_line_next;

  logic        hs_act, vs_act, h_edge, v_edge, bad_now, frame_ok, lock_lost;
  logic [11:0] h_meas;
  logic        in_h, in_v;
  logic        pix_valid_next, frame_start_next;
  logic [11:0] pix_x_next, pix_y_next, pix_rgb_next, line_len_next, frame_lines_next;
  logic [7:0]  err_cnt_next;

  // Normalise both syncs to "1 = active" so edge detection ignores polarity.
  assign hs_act = SYNC_NEG ? ~hsync : hsync;
  assign vs_act = SYNC_NEG ? ~vsync : vsync;
  assign h_edge = pix_en & hs_act & ~hs_prev_reg;
  assign v_edge = pix_en & vs_act & ~vs_prev_reg;
  assign h_meas = hcnt_reg + 12'd1;
  assign bad_now = h_edge && (h_meas != H_TOT);
  // A coincident hsync edge closes the last line of the frame, so it counts too.
  assign frame_ok = ((ln_reg + 12'd1) == V_TOT) && !bad_line_reg && !bad_now;

  // Counters, measurements and the pixel stream.
  always_comb begin
    hs_prev_next     = hs_prev_reg;
    vs_prev_next     = vs_prev_reg;
    hcnt_next        = hcnt_reg;
    ln_next          = ln_reg;
    bad_line_next    = bad_line_reg;
    line_len_next    = line_len;
    frame_lines_next = frame_lines;
    pix_rgb_next     = pix_rgb;
    frame_start_next = 1'b0;
    if (pix_en) begin
      hs_prev_next = hs_act;
      vs_prev_next = vs_act;
      pix_rgb_next = rgb;
      if (h_edge) begin
        line_len_next = h_meas;
        hcnt_next     = 12'd0;
      end else if (hcnt_reg != 12'hFFF) begin
        hcnt_next = hcnt_reg + 12'd1;
      end
      if (v_edge) begin
        // vsync wins over a coincident hsync edge: the row restarts at 0.
        frame_lines_next = ln_reg + 12'd1;
        ln_next          = 12'd0;
        bad_line_next    = 1'b0;
        frame_start_next = 1'b1;
      end else begin
        if (h_edge && ln_reg != 12'hFFF) ln_next = ln_reg + 12'd1;
        if (bad_now) bad_line_next = 1'b1;
      end
    end
  end

  // Lock FSM: moves only on vsync edges, except a bad line while locked.
  always_comb begin
    state_next = state_reg;
    lock_lost  = 1'b0;
    case (state_reg)
      ST_SEARCH:  if (v_edge) state_next = ST_MEASURE;
      ST_MEASURE: if (v_edge && frame_ok) state_next = ST_VERIFY;
      ST_VERIFY:  if (v_edge) state_next = frame_ok ? ST_LOCKED : ST_MEASURE;
      ST_LOCKED: begin
        if ((v_edge && !frame_ok) || (!v_edge && bad_now)) begin
          state_next = ST_MEASURE;
          lock_lost  = 1'b1;
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  assign err_cnt_next = (lock_lost && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;

  // Window test uses the post-update counts so outputs describe this sample.
  assign in_h = (hcnt_next >= H_START) && (hcnt_next < H_END);
  assign in_v = (ln_next >= V_START) && (ln_next < V_END);
  assign pix_valid_next = pix_en && (state_next == ST_LOCKED) && in_h && in_v;
  assign pix_x_next = pix_valid_next ? hcnt_next - H_START : 12'd0;
  assign pix_y_next = pix_valid_next ? ln_next - V_START : 12'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_SEARCH;
      hs_prev_reg  <= 1'b0;
      vs_prev_reg  <= 1'b0;
      hcnt_reg     <= 12'd0;
      ln_reg       <= 12'd0;
      bad_line_reg <= 1'b0;
      locked       <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= 12'd0;
      pix_y        <= 12'd0;
      pix_rgb      <= 12'd0;
      frame_start  <= 1'b0;
      line_len     <= 12'd0;
      frame_lines  <= 12'd0;
      err_cnt      <= 8'd0;
    end else begin
      state_reg    <= state_next;
      hs_prev_reg  <= hs_prev_next;
      vs_prev_reg  <= vs_prev_next;
      hcnt_reg     <= hcnt_next;
      ln_reg       <= ln_next;
      bad_line_reg <= bad_line_next;
      locked       <= (state_next == ST_LOCKED);
      pix_valid    <= pix_valid_next;
      pix_x        <= pix_x_next;
      pix_y        <= pix_y_next;
      pix_rgb      <= pix_rgb_next;
      frame_start  <= frame_start_next;
      line_len     <= line_len_next;
      frame_lines  <= frame_lines_next;
      err_cnt      <= err_cnt_next;
    end
  end

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_reg, crc_next, frame_crc_next;
  logic        frame_locked_reg, frame_locked_next, crc_valid_next;
  logic [15:0] crc_chain [0:12];

  // Twelve unrolled CRC-16-CCITT steps, MSB of the pixel first.
  assign crc_chain[0] = crc_reg;
  for (genvar gi = 0; gi < 12; gi++) begin : g_crc
    logic fb;
    assign fb = crc_chain[gi][15] ^ rgb[11-gi];
    assign crc_chain[gi+1] = {crc_chain[gi][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  // frame_locked_reg stays set only while every sample since the last vsync
  // edge was taken in LOCKED; a frame that drops lock restarts the CRC silently.
  always_comb begin
    crc_next          = crc_reg;
    frame_locked_next = frame_locked_reg;
    frame_crc_next    = frame_crc;
    crc_valid_next    = 1'b0;
    if (v_edge) begin
      crc_valid_next    = frame_locked_reg && (state_next == ST_LOCKED);
      if (crc_valid_next) frame_crc_next = crc_reg;
      crc_next          = 16'hFFFF;
      frame_locked_next = (state_next == ST_LOCKED);
    end else begin
      if (state_next != ST_LOCKED) frame_locked_next = 1'b0;
      if (pix_valid_next) crc_next = crc_chain[12];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg          <= 16'hFFFF;
      frame_locked_reg <= 1'b0;
      frame_crc        <= 16'd0;
      crc_valid        <= 1'b0;
    end else begin
      crc_reg          <= crc_next;
      frame_locked_reg <= frame_locked_next;
      frame_crc        <= frame_crc_next;
      crc_valid        <= crc_valid_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced video mode (8x6 total, 4x3
// active) so that many frames fit in a short run. Expected active pixels are
// queued as they are driven and compared when the decoder emits them.
module tb_vga_sync_decoder;
  localparam int HA = 4, HS = 1, HB = 1, HT = 8;
  localparam int VA = 3, VS = 1, VB = 1, VT = 6;
  localparam bit SNEG = 1'b1;

  logic clk = 1'b0;
  logic rst, pix_en, hsync, vsync;
  logic [11:0] rgb;
  logic locked, pix_valid, frame_start;
  logic [11:0] pix_x, pix_y, pix_rgb, line_len, frame_lines;
  logic [7:0] err_cnt;
`ifdef VGA_DEC_CRC_EN
  logic [15:0] frame_crc;
  logic crc_valid;
  int crc_pulses = 0;
`endif

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int err_exp = 0;
  bit exp_locked = 1'b0;
  bit mon_on = 1'b0;
  logic [35:0] sb_q[$];
  logic [35:0] mon_exp;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .SYNC_NEG(SNEG)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_start(frame_start), .line_len(line_len),
    .frame_lines(frame_lines), .err_cnt(err_cnt)
`ifdef VGA_DEC_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every pix_valid pops the oldest expected pixel.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (pix_valid) begin
        pv_cnt++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL pix_extra: got x=%0d y=%0d rgb=%h, expected no pixel", pix_x, pix_y, pix_rgb);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({pix_x, pix_y, pix_rgb} !== mon_exp) begin
            errors++;
            $display("FAIL pix_data: got x=%0d y=%0d rgb=%h, expected x=%0d y=%0d rgb=%h",
                     pix_x, pix_y, pix_rgb, mon_exp[35:24], mon_exp[23:12], mon_exp[11:0]);
          end
        end
      end else if ({pix_x, pix_y} !== 24'd0) begin
        errors++;
        $display("FAIL pix_idle_xy: got x=%0d y=%0d, expected 0/0 with pix_valid=0", pix_x, pix_y);
      end
    end
  end

`ifdef VGA_DEC_CRC_EN
  always @(negedge clk) if (crc_valid === 1'b1) crc_pulses++;

  function automatic logic [15:0] crc_model(input int npx, input logic [11:0] c);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int n = 0; n < npx; n++)
      for (int b = 11; b >= 0; b--)
        r = (r[15] ^ c[b]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  // One pixel strobe at line l, position p, followed by gap idle clocks.
  task automatic drive_px(input int l, input int p, input int gap, input logic [11:0] c);
    logic hs_a, vs_a;
    bit act;
    hs_a = (p < HS);
    vs_a = (l < VS);
    act = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
    hsync = SNEG ? ~hs_a : hs_a;
    vsync = SNEG ? ~vs_a : vs_a;
    rgb = c;
    pix_en = 1'b1;
    if (act && exp_locked) sb_q.push_back({12'(p - (HS + HB)), 12'(l - (VS + VB)), c});
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Lines l0..l1-1; the first line starts at pixel p0; line long_l gets one extra pixel.
  task automatic send_lines(input int l0, input int l1, input int p0, input int long_l,
                            input int gap, input logic [11:0] color, input bit rnd);
    int len;
    for (int l = l0; l < l1; l++) begin
      len = HT + ((l == long_l) ? 1 : 0);
      for (int p = (l == l0) ? p0 : 0; p < len; p++)
        drive_px(l, p, gap, rnd ? 12'($urandom) : color);
    end
  endtask

  task automatic send_frame(input int nl, input int gap);
    send_lines(0, nl, 0, -1, gap, 12'h000, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 12'hABC;
    for (int i = 0; i < 3; i++) begin
      pix_en = i[0];
      @(posedge clk); #1;
    end
    pix_en = 1'b0;
    checks++;
    if ({locked, pix_valid, frame_start} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, expected 000", {locked, pix_valid, frame_start});
    end
    checks++;
    if ({pix_x, pix_y, pix_rgb} !== 36'd0) begin
      errors++; $display("FAIL reset_pix: got %h, expected 0", {pix_x, pix_y, pix_rgb});
    end
    checks++;
    if ({line_len, frame_lines, err_cnt} !== 32'd0) begin
      errors++; $display("FAIL reset_meas: got %h, expected 0", {line_len, frame_lines, err_cnt});
    end
    rst = 1'b0;
    mon_on = 1'b1;
    $display("test_reset: outputs after reset locked=%0d err_cnt=%0d", locked, err_cnt);
  endtask

  task automatic test_lock;
    send_frame(VT, 3);
    send_frame(VT, 3);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL lock_early: got locked=%b, expected 0 before 3rd vsync edge", locked);
    end
    drive_px(0, 0, 3, 12'h000);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_3rd_edge: got locked=%b, expected 1", locked);
    end
    checks++;
    if ({line_len, frame_lines} !== {12'(HT), 12'(VT)}) begin
      errors++; $display("FAIL lock_meas: got line_len=%0d frame_lines=%0d, expected %0d/%0d", line_len, frame_lines, HT, VT);
    end
    exp_locked = 1'b1;
    pv_cnt = 0;
    send_lines(0, VT, 1, -1, 3, 12'h000, 1'b1);
    checks++;
    if (pv_cnt != HA * VA || sb_q.size() != 0) begin
      errors++; $display("FAIL lock_pix_count: got %0d (queued %0d), expected %0d", pv_cnt, sb_q.size(), HA * VA);
    end
    $display("test_lock: locked=%0d pixels=%0d", locked, pv_cnt);
  endtask

  task automatic test_long_line;
    send_lines(0, 3, 0, 2, 1, 12'h000, 1'b1);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL long_pre: got locked=%b, expected 1", locked);
    end
    drive_px(3, 0, 0, 12'h000);
    err_exp++;
    checks++;
    if (locked !== 1'b0 || err_cnt !== 8'(err_exp)) begin
      errors++; $display("FAIL long_drop: got locked=%b err_cnt=%0d, expected 0/%0d", locked, err_cnt, err_exp);
    end
    checks++;
    if (line_len !== 12'(HT + 1)) begin
      errors++; $display("FAIL long_len: got %0d, expected %0d", line_len, HT + 1);
    end
    exp_locked = 1'b0;
    send_lines(3, VT, 1, -1, 1, 12'h000, 1'b1);
    send_frame(VT, 1);
    send_frame(VT, 1);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL long_relock_early: got locked=%b, expected 0", locked);
    end
    drive_px(0, 0, 0, 12'h000);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL long_relock: got locked=%b, expected 1", locked);
    end
    exp_locked = 1'b1;
    send_lines(0, VT, 1, -1, 1, 12'h000, 1'b1);
    $display("test_long_line: err_cnt=%0d line_len after bad line checked", err_cnt);
  endtask

  task automatic test_short_frames;
    for (int i = 0; i < 260; i++) begin
      exp_locked = 1'b1;
      send_frame(VT - 1, 0);
      drive_px(0, 0, 0, 12'h000);
      err_exp++;
      if (i == 0) begin
        checks++;
        if (frame_lines !== 12'(VT - 1) || locked !== 1'b0) begin
          errors++; $display("FAIL short_frame: got frame_lines=%0d locked=%b, expected %0d/0", frame_lines, locked, VT - 1);
        end
      end
      checks++;
      if (err_cnt !== 8'((err_exp > 255) ? 255 : err_exp)) begin
        errors++; $display("FAIL short_err_cnt: got %0d, expected %0d", err_cnt, (err_exp > 255) ? 255 : err_exp);
      end
      $display("test_short_frames: error frame %0d err_cnt=%0d", i, err_cnt);
      exp_locked = 1'b0;
      send_lines(0, VT, 1, -1, 0, 12'h000, 1'b1);
      send_frame(VT, 0);
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL err_saturate: got %0d, expected 255", err_cnt);
    end
  endtask

  task automatic test_coincident_edges;
    logic [11:0] ll, fl;
    logic lk;
    exp_locked = 1'b1;
    send_frame(VT, 0);
    drive_px(0, 0, 0, 12'h000);
    checks++;
    if (frame_start !== 1'b1 || locked !== 1'b1) begin
      errors++; $display("FAIL coinc_start: got frame_start=%b locked=%b, expected 1/1", frame_start, locked);
    end
    ll = line_len; fl = frame_lines; lk = locked;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (frame_start !== 1'b0 || {line_len, frame_lines, locked} !== {ll, fl, lk}) begin
        errors++; $display("FAIL coinc_hold: got frame_start=%b line_len=%0d frame_lines=%0d locked=%b, expected 0/%0d/%0d/%b",
                           frame_start, line_len, frame_lines, locked, ll, fl, lk);
      end
    end
    send_lines(0, VT, 1, -1, 3, 12'h000, 1'b1);
    drive_px(0, 0, 0, 12'h000);
    checks++;
    if ({line_len, frame_lines} !== {12'(HT), 12'(VT)}) begin
      errors++; $display("FAIL coinc_len: got line_len=%0d frame_lines=%0d, expected %0d/%0d", line_len, frame_lines, HT, VT);
    end
    $display("test_coincident_edges: frame_lines=%0d", frame_lines);
  endtask

  task automatic test_mid_reset;
    send_lines(0, VT, 1, -1, 0, 12'hF00, 1'b0);
    drive_px(0, 0, 0, 12'hF00);
`ifdef VGA_DEC_CRC_EN
    checks++;
    if (crc_valid !== 1'b1 || frame_crc !== crc_model(HA * VA, 12'hF00)) begin
      errors++; $display("FAIL crc_locked: got valid=%b crc=%h, expected 1/%h", crc_valid, frame_crc, crc_model(HA * VA, 12'hF00));
    end
`endif
    send_lines(0, 3, 1, -1, 0, 12'hF00, 1'b0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    exp_locked = 1'b0;
    err_exp = 0;
    checks++;
    if ({locked, err_cnt, line_len, frame_lines} !== 33'd0) begin
      errors++; $display("FAIL midrst_clear: got locked=%b err=%0d ll=%0d fl=%0d, expected all 0", locked, err_cnt, line_len, frame_lines);
    end
`ifdef VGA_DEC_CRC_EN
    crc_pulses = 0;
`endif
    send_lines(3, VT, 0, -1, 0, 12'hF00, 1'b0);
    send_lines(0, VT, 0, -1, 0, 12'hF00, 1'b0);
    send_lines(0, VT, 0, -1, 0, 12'hF00, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL midrst_early: got locked=%b, expected 0", locked);
    end
    drive_px(0, 0, 0, 12'hF00);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL midrst_relock: got locked=%b err=%0d, expected 1/0", locked, err_cnt);
    end
    exp_locked = 1'b1;
    send_lines(0, VT, 1, -1, 0, 12'hF00, 1'b0);
`ifdef VGA_DEC_CRC_EN
    checks++;
    if (crc_pulses != 0) begin
      errors++; $display("FAIL crc_after_rst: got %0d pulses, expected 0 before a full locked frame", crc_pulses);
    end
`endif
    drive_px(0, 0, 0, 12'hF00);
`ifdef VGA_DEC_CRC_EN
    checks++;
    if (crc_valid !== 1'b1 || frame_crc !== crc_model(HA * VA, 12'hF00)) begin
      errors++; $display("FAIL crc_relock: got valid=%b crc=%h, expected 1/%h", crc_valid, frame_crc, crc_model(HA * VA, 12'hF00));
    end
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending pixels, expected 0", sb_q.size());
    end
    $display("test_mid_reset: relocked=%0d", locked);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_long_line();
    test_short_frames();
    test_coincident_edges();
    test_mid_reset();
    @(posedge clk); #1;
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
